change_calculator: RTL and testbench



---
 rtl/change_calculator.sv | 79 +++++++
 tb/tb_change_calculator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/change_calculator.sv
// rtl/change_calculator.sv - vending change block: latched refund = amount - price, clamped at zero
module change_calculator #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] current_amount_display,
  input  logic [WIDTH-1:0] product_price,
  input  logic             change_dispense_en,
  input  logic             single_change_calculator,
  output logic [WIDTH-1:0] change_out,
  output logic             change_dispense_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             en_prev;
  logic             req;
  logic [WIDTH-1:0] change_nxt;
  logic             done_nxt;

  // Only a rising edge of enable with the qualifier high counts as a request.
  assign req = change_dispense_en & single_change_calculator & ~en_prev;

  // rst_n is active-high here despite its suffix.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      en_prev <= 1'b0;
    end else begin
      state   <= state_nxt;
      en_prev <= change_dispense_en;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    if (!change_dispense_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    change_nxt = change_out;
    done_nxt   = change_dispense_done;
    case (state)
      IDLE: if (req) done_nxt = 1'b0;
      CALC: begin
        // Insufficient funds refund nothing rather than wrapping.
        if (current_amount_display >= product_price)
          change_nxt = current_amount_display - product_price;
        else
          change_nxt = '0;
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      change_out           <= '0;
      change_dispense_done <= 1'b0;
    end else begin
      change_out           <= change_nxt;
      change_dispense_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_change_calculator.sv
// tb/tb_change_calculator.sv - table-driven bench for change_calculator
module tb_change_calculator;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] current_amount_display;
  logic [WIDTH-1:0] product_price;
  logic             change_dispense_en;
  logic             single_change_calculator;
  logic [WIDTH-1:0] change_out;
  logic             change_dispense_done;

  int errors = 0;
  int checks = 0;

  change_calculator #(.WIDTH(WIDTH)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .current_amount_display   (current_amount_display),
    .product_price            (product_price),
    .change_dispense_en       (change_dispense_en),
    .single_change_calculator (single_change_calculator),
    .change_out               (change_out),
    .change_dispense_done     (change_dispense_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] amount;
    logic [WIDTH-1:0] price;
    logic             qual;
    int               en_cycles;
    logic [WIDTH-1:0] exp_change;
    logic             exp_done;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] got_change, input logic got_done,
                       input logic [WIDTH-1:0] exp_change, input logic exp_done);
    checks++;
    if (got_change !== exp_change || got_done !== exp_done) begin
      errors++;
      $display("FAIL %s: change_out=%0d done=%0b, expected change_out=%0d done=%0b",
               name, got_change, got_done, exp_change, exp_done);
    end
  endtask

  initial begin
    vecs[0] = '{5'd20, 5'd15, 1'b1, 2, 5'd5,  1'b1};
    vecs[1] = '{5'd25, 5'd5,  1'b1, 2, 5'd20, 1'b1};
    vecs[2] = '{5'd10, 5'd10, 1'b1, 2, 5'd0,  1'b1};
    vecs[3] = '{5'd8,  5'd10, 1'b1, 2, 5'd0,  1'b1};
    vecs[4] = '{5'd31, 5'd0,  1'b1, 2, 5'd31, 1'b1};
    vecs[5] = '{5'd31, 5'd31, 1'b1, 2, 5'd0,  1'b1};
    vecs[6] = '{5'd0,  5'd31, 1'b1, 2, 5'd0,  1'b1};
    vecs[7] = '{5'd17, 5'd3,  1'b0, 2, 5'd0,  1'b1};
    vecs[8] = '{5'd30, 5'd1,  1'b1, 3, 5'd29, 1'b1};

    rst_n = 1'b1;
    current_amount_display = '0;
    product_price = '0;
    change_dispense_en = 1'b0;
    single_change_calculator = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("reset", change_out, change_dispense_done, 5'd0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      current_amount_display = vecs[i].amount;
      product_price = vecs[i].price;
      single_change_calculator = vecs[i].qual;
      change_dispense_en = 1'b1;
      for (int c = 0; c < vecs[i].en_cycles; c++) tick();
      change_dispense_en = 1'b0;
      single_change_calculator = 1'b0;
      tick();
      check($sformatf("vec%0d", i), change_out, change_dispense_done,
            vecs[i].exp_change, vecs[i].exp_done);
    end

    // done clears on the request edge while change_out holds, then result appears
    current_amount_display = 5'd25;
    product_price = 5'd5;
    single_change_calculator = 1'b1;
    change_dispense_en = 1'b1;
    tick();
    check("done_clear", change_out, change_dispense_done, 5'd29, 1'b0);
    tick();
    check("done_set", change_out, change_dispense_done, 5'd20, 1'b1);
    change_dispense_en = 1'b0;
    tick();
    check("done_sticky", change_out, change_dispense_done, 5'd20, 1'b1);

    // held enable with changing inputs: single calc using values at the CALC edge
    current_amount_display = 5'd20;
    product_price = 5'd4;
    change_dispense_en = 1'b1;
    tick();
    current_amount_display = 5'd12;
    product_price = 5'd2;
    tick();
    check("hold_calc", change_out, change_dispense_done, 5'd10, 1'b1);
    for (int c = 0; c < 3; c++) begin
      current_amount_display = 5'(c * 9 + 3);
      product_price = 5'd1;
      tick();
      check($sformatf("hold_%0d", c), change_out, change_dispense_done, 5'd10, 1'b1);
    end
    change_dispense_en = 1'b0;
    tick();
    check("hold_end", change_out, change_dispense_done, 5'd10, 1'b1);

    // qualifier rising after enable edge is ignored
    current_amount_display = 5'd31;
    product_price = 5'd2;
    single_change_calculator = 1'b0;
    change_dispense_en = 1'b1;
    tick();
    single_change_calculator = 1'b1;
    tick();
    tick();
    tick();
    check("late_qual", change_out, change_dispense_done, 5'd10, 1'b1);
    change_dispense_en = 1'b0;
    tick();
    check("late_qual_end", change_out, change_dispense_done, 5'd10, 1'b1);

    // reset pulsed while in CALC
    current_amount_display = 5'd30;
    product_price = 5'd1;
    change_dispense_en = 1'b1;
    tick();
    rst_n = 1'b1;
    change_dispense_en = 1'b0;
    tick();
    check("rst_calc", change_out, change_dispense_done, 5'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_idle", change_out, change_dispense_done, 5'd0, 1'b0);
    current_amount_display = 5'd9;
    product_price = 5'd2;
    change_dispense_en = 1'b1;
    tick();
    tick();
    check("after_rst", change_out, change_dispense_done, 5'd7, 1'b1);
    change_dispense_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
